mem_port_arbiter: RTL and testbench

//  Shares one single-port valid/ready memory between instruction fetch (IF) and data memory (DM) stage.

---
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one valid/ready memory port between instruction fetch and data access (data wins).
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   output logic [DW-1:0]   if_rdata,
   output logic            if_ack,
   output logic            if_stall,
   input  logic            dm_req,
   input  logic            dm_we,
   input  logic [AW-1:0]   dm_addr,
   input  logic [DW-1:0]   dm_wdata,
   input  logic [DW/8-1:0] dm_wstrb,
   output logic [DW-1:0]   dm_rdata,
   output logic            dm_ack,
   output logic            dm_stall,
   input  logic            flush,
   output logic            mem_valid,
   input  logic            mem_ready,
   output logic [AW-1:0]   mem_addr,
   output logic            mem_we,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_wstrb,
   input  logic [DW-1:0]   mem_rdata,
   output logic            timeout_err
);

   typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

   state_t            state_q, state_d;
   logic              mem_valid_q, mem_valid_d;
   logic              mem_we_q, mem_we_d;
   logic [AW-1:0]     mem_addr_q, mem_addr_d;
   logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
   logic [DW/8-1:0]   mem_wstrb_q, mem_wstrb_d;
   logic              if_ack_q, if_ack_d;
   logic              dm_ack_q, dm_ack_d;
   logic [DW-1:0]     if_rdata_q, if_rdata_d;
   logic [DW-1:0]     dm_rdata_q, dm_rdata_d;
   logic              discard_q, discard_d;
   logic              handshake;

   assign handshake = mem_valid_q & mem_ready;

   always_comb begin
      state_d     = state_q;
      mem_valid_d = mem_valid_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      discard_d   = discard_q;
      if_ack_d    = 1'b0;
      dm_ack_d    = 1'b0;
      case (state_q)
         IDLE: begin
            discard_d = 1'b0;
            // A port whose ack is on the wire this cycle is not re-granted.
            if (dm_req && !dm_ack_q) begin
               state_d     = DATA;
               mem_valid_d = 1'b1;
               mem_addr_d  = dm_addr;
               mem_we_d    = dm_we;
               mem_wdata_d = dm_wdata;
               mem_wstrb_d = dm_wstrb;
            end else if (if_req && !if_ack_q) begin
               state_d     = FETCH;
               mem_valid_d = 1'b1;
               mem_addr_d  = if_addr;
               mem_we_d    = 1'b0;
               mem_wstrb_d = '0;
            end
         end
         FETCH: begin
            if (flush) discard_d = 1'b1;
            if (handshake) begin
               state_d     = IDLE;
               mem_valid_d = 1'b0;
               if_rdata_d  = mem_rdata;
               if_ack_d    = ~(discard_q | flush);
               discard_d   = 1'b0;
            end
         end
         DATA: begin
            if (handshake) begin
               state_d     = IDLE;
               mem_valid_d = 1'b0;
               dm_rdata_d  = mem_rdata;
               dm_ack_d    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= IDLE;
         mem_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         discard_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_valid_q <= mem_valid_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_ack_q    <= if_ack_d;
         dm_ack_q    <= dm_ack_d;
         discard_q   <= discard_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] wdog_cnt_q, wdog_cnt_d;
   logic          timeout_err_q, timeout_err_d;

   // Counter saturates at the limit; the flag stays set until reset.
   always_comb begin
      wdog_cnt_d    = wdog_cnt_q;
      timeout_err_d = timeout_err_q;
      if (handshake) begin
         wdog_cnt_d = '0;
      end else if (mem_valid_q && wdog_cnt_q != CW'(TIMEOUT_CYCLES)) begin
         wdog_cnt_d = wdog_cnt_q + 1'b1;
         if (wdog_cnt_d == CW'(TIMEOUT_CYCLES)) timeout_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wdog_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         wdog_cnt_q    <= wdog_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_err        = 1'b0;
`endif

   assign mem_valid = mem_valid_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign if_ack    = if_ack_q;
   assign dm_ack    = dm_ack_q;
   assign if_stall  = if_req & ~if_ack_q;
   assign dm_stall  = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; memory read data is address ^ 0xC0DE0000.
// Timeout expectations follow ARB_TIMEOUT_EN (limit set to 4 here).
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack, if_stall;
   logic        dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic [3:0]  dm_wstrb;
   logic [31:0] dm_rdata;
   logic        dm_ack, dm_stall;
   logic        flush;
   logic        mem_valid, mem_ready, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;

`ifdef ARB_TIMEOUT_EN
   localparam logic TO_EXP = 1'b1;
`else
   localparam logic TO_EXP = 1'b0;
`endif

   always #5 clk = ~clk;

   assign mem_rdata = mem_addr ^ 32'hC0DE_0000;

   mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .resetn(resetn),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
      .flush(flush),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .timeout_err(timeout_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; if_req = 1'b1; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
      dm_addr = '0; dm_wdata = '0; dm_wstrb = '0; flush = 1'b0; mem_ready = 1'b0;
      tick(); tick();
      checks++;
      if ({mem_valid, mem_we, if_ack, dm_ack, timeout_err} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl got %b exp 00000", {mem_valid, mem_we, if_ack, dm_ack, timeout_err});
      end
      checks++;
      if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin
         errors++; $display("FAIL reset_data got %h/%h/%h exp 0", mem_addr, mem_wdata, mem_wstrb);
      end
      checks++;
      if ({if_stall, dm_stall} !== 2'b10) begin
         errors++; $display("FAIL reset_stall got %b exp 10", {if_stall, dm_stall});
      end
      if_req = 1'b0; resetn = 1'b1;
      tick();
      checks++;
      if (mem_valid !== 1'b0) begin
         errors++; $display("FAIL reset_idle mem_valid got %b exp 0", mem_valid);
      end
   endtask

   task automatic test_single_fetch();
      if_addr = 32'h100; if_req = 1'b1; mem_ready = 1'b1;
      #1;
      checks++;
      if ({if_stall, mem_valid} !== 2'b10) begin
         errors++; $display("FAIL fetch_c0 stall/valid got %b exp 10", {if_stall, mem_valid});
      end
      tick();
      checks++;
      if ({mem_valid, mem_we, if_ack, if_stall} !== 4'b1001 || mem_addr !== 32'h100) begin
         errors++; $display("FAIL fetch_c1 got v/we/ack/st=%b addr=%h exp 1001 100",
                            {mem_valid, mem_we, if_ack, if_stall}, mem_addr);
      end
      tick();
      checks++;
      if ({if_ack, mem_valid, if_stall} !== 3'b100 || if_rdata !== 32'hC0DE_0100) begin
         errors++; $display("FAIL fetch_c2 got ack/v/st=%b rdata=%h exp 100 c0de0100",
                            {if_ack, mem_valid, if_stall}, if_rdata);
      end
      if_req = 1'b0;
      tick();
      checks++;
      if ({if_ack, mem_valid} !== 2'b00 || if_rdata !== 32'hC0DE_0100) begin
         errors++; $display("FAIL fetch_c3 got ack/v=%b rdata=%h exp 00 c0de0100", {if_ack, mem_valid}, if_rdata);
      end
   endtask

   task automatic test_priority();
      if_req = 1'b1; if_addr = 32'h180; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000; mem_ready = 1'b1;
      tick();
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h2000 || mem_we !== 1'b0) begin
         errors++; $display("FAIL prio_dm_grant got v=%b addr=%h we=%b exp 1 2000 0", mem_valid, mem_addr, mem_we);
      end
      tick();
      checks++;
      if ({dm_ack, if_ack, mem_valid} !== 3'b100 || dm_rdata !== 32'hC0DE_2000) begin
         errors++; $display("FAIL prio_dm_ack got ack/ack/v=%b rdata=%h exp 100 c0de2000",
                            {dm_ack, if_ack, mem_valid}, dm_rdata);
      end
      dm_req = 1'b0;
      #1;
      checks++;
      if ({dm_stall, if_stall} !== 2'b01) begin
         errors++; $display("FAIL prio_stalls got %b exp 01", {dm_stall, if_stall});
      end
      tick();
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h180 || dm_ack !== 1'b0) begin
         errors++; $display("FAIL prio_if_grant got v=%b addr=%h dm_ack=%b exp 1 180 0", mem_valid, mem_addr, dm_ack);
      end
      tick();
      checks++;
      if (if_ack !== 1'b1 || if_rdata !== 32'hC0DE_0180) begin
         errors++; $display("FAIL prio_if_ack got ack=%b rdata=%h exp 1 c0de0180", if_ack, if_rdata);
      end
      if_req = 1'b0; mem_ready = 1'b0;
      tick();
      checks++;
      if ({mem_valid, if_ack, dm_ack} !== 3'b000) begin
         errors++; $display("FAIL prio_no_regrant got %b exp 000", {mem_valid, if_ack, dm_ack});
      end
   endtask

   task automatic test_store_wait();
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'b0011; mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_ready = 1'b1;
         checks++;
         if ({mem_valid, mem_we} !== 2'b11 || mem_addr !== 32'h40 || mem_wdata !== 32'hDEAD_BEEF ||
             mem_wstrb !== 4'b0011 || dm_ack !== 1'b0) begin
            errors++; $display("FAIL store_hold[%0d] got v/we=%b addr=%h wd=%h st=%b ack=%b exp 11 40 deadbeef 0011 0",
                               i, {mem_valid, mem_we}, mem_addr, mem_wdata, mem_wstrb, dm_ack);
         end
         tick();
      end
      checks++;
      if ({dm_ack, mem_valid} !== 2'b10) begin
         errors++; $display("FAIL store_ack got ack/v=%b exp 10", {dm_ack, mem_valid});
      end
      dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
      tick();
      checks++;
      if (dm_ack !== 1'b0) begin
         errors++; $display("FAIL store_ack_width got %b exp 0", dm_ack);
      end
   endtask

   task automatic test_flush();
      if_req = 1'b1; if_addr = 32'h200; mem_ready = 1'b0;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0; mem_ready = 1'b1;
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h200) begin
         errors++; $display("FAIL flush_hold got v=%b addr=%h exp 1 200", mem_valid, mem_addr);
      end
      tick();
      checks++;
      if ({if_ack, mem_valid} !== 2'b00) begin
         errors++; $display("FAIL flush_drop got ack/v=%b exp 00", {if_ack, mem_valid});
      end
      if_addr = 32'h300;
      tick();
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h300) begin
         errors++; $display("FAIL flush_newpc got v=%b addr=%h exp 1 300", mem_valid, mem_addr);
      end
      tick();
      checks++;
      if (if_ack !== 1'b1 || if_rdata !== 32'hC0DE_0300) begin
         errors++; $display("FAIL flush_newpc_ack got ack=%b rdata=%h exp 1 c0de0300", if_ack, if_rdata);
      end
      if_req = 1'b0; mem_ready = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_data();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000; mem_ready = 1'b0;
      tick();
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h3000) begin
         errors++; $display("FAIL rst_mid_grant got v=%b addr=%h exp 1 3000", mem_valid, mem_addr);
      end
      resetn = 1'b0;
      tick();
      checks++;
      if ({mem_valid, dm_ack, if_ack, dm_stall} !== 4'b0001 || mem_addr !== 32'h0) begin
         errors++; $display("FAIL rst_mid_clear got v/ack/ack/st=%b addr=%h exp 0001 0",
                            {mem_valid, dm_ack, if_ack, dm_stall}, mem_addr);
      end
      resetn = 1'b1;
      tick();
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h3000) begin
         errors++; $display("FAIL rst_mid_reissue got v=%b addr=%h exp 1 3000", mem_valid, mem_addr);
      end
      mem_ready = 1'b1;
      tick();
      checks++;
      if (dm_ack !== 1'b1 || dm_rdata !== 32'hC0DE_3000) begin
         errors++; $display("FAIL rst_mid_ack got ack=%b rdata=%h exp 1 c0de3000", dm_ack, dm_rdata);
      end
      dm_req = 1'b0; mem_ready = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      if_req = 1'b1; if_addr = 32'h400; mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++; $display("FAIL timeout_early got %b exp 0", timeout_err);
      end
      tick();
      checks++;
      if (timeout_err !== TO_EXP || mem_valid !== 1'b1) begin
         errors++; $display("FAIL timeout_set got err=%b v=%b exp %b 1", timeout_err, mem_valid, TO_EXP);
      end
      mem_ready = 1'b1;
      tick();
      checks++;
      if (if_ack !== 1'b1 || timeout_err !== TO_EXP) begin
         errors++; $display("FAIL timeout_ack got ack=%b err=%b exp 1 %b", if_ack, timeout_err, TO_EXP);
      end
      if_req = 1'b0; mem_ready = 1'b0;
      tick();
      checks++;
      if (timeout_err !== TO_EXP) begin
         errors++; $display("FAIL timeout_sticky got %b exp %b", timeout_err, TO_EXP);
      end
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_priority();
      test_store_wait();
      test_flush();
      test_reset_mid_data();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
